// File: rtl/mini_mips_multicycle.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB over one shared req/ready memory port.
// Latency: 3 cycles (branch/jump), 4 (ALU, sw), 5 (lw) at zero wait; each wait cycle adds one.
// Backpressure: FETCH and MEM hold mem_req and its address/data stable until mem_ready accepts.
module mini_mips_multicycle #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ADDR_W       = 32,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic [31:0]       result,
  output logic              retired,
  output logic              halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW  = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_J   = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A, FN_SLL = 6'h00, FN_JR  = 6'h08;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_alu_out, r_mdr, r_target, r_result;
  logic [31:0] r_rf [32];

  // Instruction field decode, always taken from the latched IR.
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [31:0] w_sext, w_pc4, w_jtarget, w_alu, w_wb_val;
  logic [4:0]  w_wb_dst;
  logic        w_is_rtype, w_is_alu_r, w_is_jr, w_is_addi, w_is_lw, w_is_sw;
  logic        w_is_beq, w_is_bne, w_is_j, w_is_jal, w_legal;

  assign w_op      = r_ir[31:26];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_shamt   = r_ir[10:6];
  assign w_funct   = r_ir[5:0];
  assign w_sext    = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_pc4     = r_pc + 32'd4;
  assign w_jtarget = {r_pc[31:28], r_ir[25:0], 2'b00};

  assign w_is_rtype = (w_op == OP_RTYPE);
  assign w_is_alu_r = w_is_rtype && (w_funct == FN_ADD || w_funct == FN_SUB || w_funct == FN_AND ||
                                     w_funct == FN_OR  || w_funct == FN_SLT || w_funct == FN_SLL);
  assign w_is_jr    = w_is_rtype && (w_funct == FN_JR);
  assign w_is_addi  = (w_op == OP_ADDI);
  assign w_is_lw    = (w_op == OP_LW);
  assign w_is_sw    = (w_op == OP_SW);
  assign w_is_beq   = (w_op == OP_BEQ);
  assign w_is_bne   = (w_op == OP_BNE);
  assign w_is_j     = (w_op == OP_J);
  assign w_is_jal   = (w_op == OP_JAL);
  assign w_legal    = w_is_alu_r | w_is_jr | w_is_addi | w_is_lw | w_is_sw |
                      w_is_beq | w_is_bne | w_is_j | w_is_jal;

  // Writeback target is rd for R-type, rt for addi/lw; load data wins over ALU result.
  assign w_wb_dst = w_is_rtype ? w_rd : w_rt;
  assign w_wb_val = w_is_lw ? r_mdr : r_alu_out;

  // ALU: address/addi add by default, R-type funct selects the operation.
  always_comb begin
    w_alu = r_a + w_sext;
    if (w_is_rtype) begin
      case (w_funct)
        FN_ADD:  w_alu = r_a + r_b;
        FN_SUB:  w_alu = r_a - r_b;
        FN_AND:  w_alu = r_a & r_b;
        FN_OR:   w_alu = r_a | r_b;
        FN_SLT:  w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
        FN_SLL:  w_alu = r_b << w_shamt;
        default: w_alu = r_a + r_b;
      endcase
    end
  end

  // Next state and memory/retire outputs; reset forces the port quiet so an access is abandoned.
  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 32'd0;
    retired     = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = r_pc[ADDR_W-1:0];
        if (mem_ready) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!w_legal && ILLEGAL_HALT) w_state_nxt = S_HALT;
        else                          w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_alu_r || w_is_addi)  w_state_nxt = S_WB;
        else if (w_is_lw || w_is_sw)  w_state_nxt = S_MEM;
        else begin
          retired     = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_addr  = r_alu_out[ADDR_W-1:0];
        mem_we    = w_is_sw;
        mem_wdata = w_is_sw ? r_b : 32'd0;
        if (mem_ready) begin
          retired     = w_is_sw;
          w_state_nxt = w_is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        retired     = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 32'd0;
      retired   = 1'b0;
    end
  end

  // State register plus datapath/register-file updates for the phase being left.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_alu_out <= 32'd0;
      r_mdr     <= 32'd0;
      r_target  <= 32'd0;
      r_result  <= 32'd0;
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_FETCH: if (mem_ready) r_ir <= mem_rdata;
        S_DECODE: begin
          r_a      <= (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
          r_b      <= (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
          r_target <= w_pc4 + {w_sext[29:0], 2'b00};
        end
        S_EXEC: begin
          if (w_is_alu_r || w_is_addi || w_is_lw || w_is_sw) r_alu_out <= w_alu;
          else if (w_is_beq) r_pc <= (r_a == r_b) ? r_target : w_pc4;
          else if (w_is_bne) r_pc <= (r_a != r_b) ? r_target : w_pc4;
          else if (w_is_j)   r_pc <= w_jtarget;
          else if (w_is_jal) begin
            r_pc      <= w_jtarget;
            r_rf[31]  <= w_pc4;
            r_result  <= w_pc4;
          end
          else if (w_is_jr)  r_pc <= r_a;
          else               r_pc <= w_pc4;  // illegal encoding retiring as NOP
        end
        S_MEM: begin
          if (mem_ready) begin
            if (w_is_sw) r_pc  <= w_pc4;
            else         r_mdr <= mem_rdata;
          end
        end
        S_WB: begin
          r_pc <= w_pc4;
          if (w_wb_dst != 5'd0) begin
            r_rf[w_wb_dst] <= w_wb_val;
            r_result       <= w_wb_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc     = r_pc;
  assign result = r_result;
  assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_mini_mips_multicycle.sv
// Bench for mini_mips_multicycle: memory model with programmable wait states and a retire scoreboard.
// Latency: expected per-instruction cycle counts are checked at each retirement.
// Backpressure: the memory model withholds mem_ready for wait_n cycles per access.
module tb_mini_mips_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, result;
  logic        retired, halted;

  logic        mem_req2, mem_we2, mem_ready2, retired2, halted2;
  logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, pc2, result2;

  logic [31:0] mem  [64];
  logic [31:0] mem2 [64];

  typedef struct {
    logic [31:0] pc;
    int          lat;
    logic [31:0] res;
  } exp_t;
  exp_t sb_q[$];

  int n_chk = 0, n_bad = 0;
  int wait_n = 0, wr_cnt = 0, stab_bad = 0;
  logic [31:0] last_wr_addr, last_wr_data;
  int cyc = 0, last = 0;
  logic pend_res = 1'b0;
  logic [31:0] pend_val;

  mini_mips_multicycle u_dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .result(result), .retired(retired), .halted(halted)
  );

  mini_mips_multicycle #(.ILLEGAL_HALT(1'b0)) u_dut_nop (
    .clk(clk), .reset(reset), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ready(mem_ready2), .pc(pc2),
    .result(result2), .retired(retired2), .halted(halted2)
  );

  assign mem_rdata2 = mem2[mem_addr2[7:2]];
  assign mem_ready2 = 1'b1;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input int op, input logic [31:0] tgt);
    return {6'(op), tgt[27:2]};
  endfunction

  task automatic expect_ret(input logic [31:0] p, input int l, input logic [31:0] r);
    exp_t e;
    e.pc = p; e.lat = l; e.res = r;
    sb_q.push_back(e);
  endtask

  task automatic apply_rst;
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
  endtask

  task automatic release_rst;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || pend_res) && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    check_eq("drain_left", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    pend_res = 1'b0;
  endtask

  // Memory model: decides mem_ready/mem_rdata each negedge, commits writes accepted at the prior edge.
  initial begin
    logic        armed, hold_vld, a_we;
    logic [31:0] a_addr, a_wdata, h_addr, h_wdata;
    logic        h_we;
    int          wcnt;
    armed = 1'b0; hold_vld = 1'b0; wcnt = 0;
    mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (armed && a_we) begin
        mem[a_addr[7:2]] = a_wdata;
        wr_cnt++;
        last_wr_addr = a_addr;
        last_wr_data = a_wdata;
      end
      armed = 1'b0;
      if (mem_req && !reset) begin
        if (hold_vld && (mem_addr != h_addr || mem_we != h_we || mem_wdata != h_wdata)) stab_bad++;
        hold_vld = 1'b1; h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
        if (wcnt >= wait_n) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[7:2]];
          armed = 1'b1; a_we = mem_we; a_addr = mem_addr; a_wdata = mem_wdata;
          wcnt = 0; hold_vld = 1'b0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hDEAD_BEEF;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        wcnt = 0; hold_vld = 1'b0;
      end
    end
  end

  // Retire monitor: pops the scoreboard on each retire, checks result one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        cyc = 0; last = 0; pend_res = 1'b0;
      end else begin
        cyc++;
        if (pend_res) begin
          check_eq("result", result, pend_val);
          pend_res = 1'b0;
        end
        if (retired && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("ret_pc", pc, e.pc);
          check_eq("ret_lat", 32'(cyc - last), 32'(e.lat));
          pend_val = e.res;
          pend_res = 1'b1;
        end
        if (retired) last = cyc;
      end
    end
  end

  initial begin
    int n, c, r1c, r2c, req_cnt, we2_cnt;
    logic [31:0] r1pc, pc2_c4;
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin mem[i] = 32'd0; mem2[i] = 32'd0; end
    mem2[0] = 32'hFC00_0000;               // opcode 0x3F
    mem2[1] = enc_i(8, 0, 1, 32'h55);      // addi r1,r0,0x55
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_pc", pc, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_retired", {31'd0, retired}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);

    // ALU sequence, zero wait
    mem[0] = enc_i(8, 0, 1, 5);
    mem[1] = enc_i(8, 0, 2, -3);
    mem[2] = enc_r(1, 2, 3, 0, 32'h20);
    mem[3] = enc_r(2, 1, 4, 0, 32'h2A);
    expect_ret(32'h0, 4, 32'd5);
    expect_ret(32'h4, 4, 32'hFFFF_FFFD);
    expect_ret(32'h8, 4, 32'd2);
    expect_ret(32'hC, 4, 32'd1);
    release_rst();
    @(negedge clk); #2;
    check_eq("first_req", {31'd0, mem_req}, 32'd1);
    check_eq("first_addr", mem_addr, 32'd0);
    wait_drain(200);
    check_eq("alu_r3", u_dut.r_rf[3], 32'd2);
    check_eq("alu_r4", u_dut.r_rf[4], 32'd1);

    // Load/store with 3 wait cycles per access
    apply_rst();
    wait_n = 3; wr_cnt = 0; stab_bad = 0;
    mem[0]  = enc_j(2, 32'h40);
    mem[16] = enc_i(8, 0, 1, 5);
    mem[17] = enc_i(32'h2B, 0, 1, 8);
    mem[18] = enc_i(32'h23, 0, 5, 8);
    expect_ret(32'h0, 6, 32'd0);
    expect_ret(32'h40, 7, 32'd5);
    expect_ret(32'h44, 10, 32'd5);
    expect_ret(32'h48, 11, 32'd5);
    release_rst();
    wait_drain(300);
    check_eq("sw_count", 32'(wr_cnt), 32'd1);
    check_eq("sw_addr", last_wr_addr, 32'd8);
    check_eq("sw_data", last_wr_data, 32'd5);
    check_eq("mem_word8", mem[2], 32'd5);
    check_eq("hold_stable", 32'(stab_bad), 32'd0);
    check_eq("lw_r5", u_dut.r_rf[5], 32'd5);

    // Control flow, zero wait
    apply_rst();
    wait_n = 0;
    mem[0]  = enc_i(8, 0, 1, 1);
    mem[1]  = enc_i(4, 1, 1, 2);
    mem[2]  = enc_i(8, 0, 2, 99);
    mem[3]  = enc_i(8, 0, 2, 99);
    mem[4]  = enc_j(3, 32'h30);
    mem[5]  = enc_i(5, 1, 1, 5);
    mem[6]  = enc_i(8, 0, 6, 32'h77);
    mem[12] = enc_r(31, 0, 0, 0, 32'h08);
    expect_ret(32'h0, 4, 32'd1);
    expect_ret(32'h4, 3, 32'd1);
    expect_ret(32'h10, 3, 32'h14);
    expect_ret(32'h30, 3, 32'h14);
    expect_ret(32'h14, 3, 32'h14);
    expect_ret(32'h18, 4, 32'h77);
    release_rst();
    wait_drain(300);
    check_eq("jal_r31", u_dut.r_rf[31], 32'h14);
    check_eq("skip_r2", u_dut.r_rf[2], 32'd0);

    // r0 discard, wrap arithmetic, remaining ALU ops
    apply_rst();
    mem[0]  = enc_i(8, 0, 1, 9);
    mem[1]  = enc_i(8, 0, 0, 7);
    mem[2]  = enc_i(32'h23, 0, 2, 32'h80);
    mem[3]  = enc_i(8, 0, 3, 1);
    mem[4]  = enc_r(2, 3, 4, 0, 32'h20);
    mem[5]  = enc_r(3, 2, 6, 0, 32'h22);
    mem[6]  = enc_r(0, 3, 5, 4, 32'h00);
    mem[7]  = enc_r(2, 6, 7, 0, 32'h25);
    mem[8]  = enc_r(2, 6, 8, 0, 32'h24);
    mem[9]  = enc_r(4, 3, 9, 0, 32'h2A);
    mem[32] = 32'h7FFF_FFFF;
    expect_ret(32'h0, 4, 32'd9);
    expect_ret(32'h4, 4, 32'd9);
    expect_ret(32'h8, 5, 32'h7FFF_FFFF);
    expect_ret(32'hC, 4, 32'd1);
    expect_ret(32'h10, 4, 32'h8000_0000);
    expect_ret(32'h14, 4, 32'h8000_0002);
    expect_ret(32'h18, 4, 32'h10);
    expect_ret(32'h1C, 4, 32'hFFFF_FFFF);
    expect_ret(32'h20, 4, 32'd2);
    expect_ret(32'h24, 4, 32'd1);
    release_rst();
    wait_drain(400);
    check_eq("r0_zero", u_dut.r_rf[0], 32'd0);

    // Illegal opcode: halting core and NOP-retiring core side by side
    apply_rst();
    mem[0] = enc_i(8, 0, 1, 3);
    mem[1] = 32'hFC00_0000;
    expect_ret(32'h0, 4, 32'd3);
    r1c = 0; r2c = 0; r1pc = 32'hFFFF_FFFF; pc2_c4 = 32'hFFFF_FFFF; we2_cnt = 0;
    release_rst();
    for (c = 1; c <= 12; c++) begin
      @(negedge clk); #2;
      if (c == 4) pc2_c4 = pc2;
      if (mem_req2 && mem_we2) we2_cnt++;
      if (retired2) begin
        if (r1c == 0) begin r1c = c; r1pc = pc2; end
        else if (r2c == 0) r2c = c;
      end
    end
    check_eq("nop_ret_cycle", 32'(r1c), 32'd3);
    check_eq("nop_ret_pc", r1pc, 32'd0);
    check_eq("nop_next_pc", pc2_c4, 32'd4);
    check_eq("nop_then_addi", 32'(r2c), 32'd7);
    check_eq("nop_result", result2, 32'h55);
    check_eq("nop_no_write", 32'(we2_cnt), 32'd0);
    wait_drain(50);
    check_eq("halted", {31'd0, halted}, 32'd1);
    check_eq("halt_pc", pc, 32'd4);
    req_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #2;
      if (mem_req) req_cnt++;
    end
    check_eq("halt_no_req", 32'(req_cnt), 32'd0);

    // Reset during a stalled lw MEM phase
    apply_rst();
    wait_n = 3;
    mem[0]  = enc_i(8, 0, 1, 5);
    mem[1]  = enc_i(32'h23, 0, 5, 32'h80);
    mem[32] = 32'h0000_1234;
    expect_ret(32'h0, 7, 32'd5);
    release_rst();
    wait_drain(100);
    n = 0;
    while (!(mem_req && mem_addr == 32'h80) && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    wait_n = 1000;
    repeat (2) begin @(negedge clk); #2; end
    check_eq("stall_req", {31'd0, mem_req}, 32'd1);
    check_eq("stall_addr", mem_addr, 32'h80);
    check_eq("stall_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_req", {31'd0, mem_req}, 32'd0);
    check_eq("abort_pc", pc, 32'd0);
    check_eq("abort_r1", u_dut.r_rf[1], 32'd0);
    check_eq("abort_r5", u_dut.r_rf[5], 32'd0);
    check_eq("abort_result", result, 32'd0);
    wait_n = 0;
    expect_ret(32'h0, 4, 32'd5);
    expect_ret(32'h4, 5, 32'h1234);
    release_rst();
    wait_drain(100);
    check_eq("restart_r5", u_dut.r_rf[5], 32'h1234);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mini_mips_multicycle.md
# mini_mips_multicycle

Multi-cycle successor to the single-cycle mini-MIPS core. Instructions execute over 3–5 cycles through a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data accesses share one external memory port with a req/ready handshake, so the core tolerates arbitrary memory wait states. The block holds its own 32×32 integer register file and sits where the single-cycle core did, between the system clock/reset and a unified memory.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of mem_addr; the low ADDR_W bits of the byte address.
- ILLEGAL_HALT, 1, 1: unsupported encoding enters HALT; 0: it retires as NOP.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- mem_req  out  1  memory access request, held until accepted
- mem_we  out  1  1 = write (sw), 0 = read
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1
- mem_ready  in  1  access completes at the edge where mem_req & mem_ready
- pc  out  32  address of the instruction in flight
- result  out  32  last value written to a nonzero register
- retired  out  1  one-cycle pulse when an instruction completes
- halted  out  1  high while in HALT

## Operation
- Supported: R-type (op 0x00) add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, jr 0x08; addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On accept, latch mem_rdata into IR and go to DECODE.
- DECODE: read rs/rt into A/B, sign-extend imm, compute branch target pc+4+(sext(imm)<<2). Go to EXEC, or to HALT/EXEC-as-NOP for an illegal encoding.
- EXEC, ALU ops: compute ALUOut, go to WB.
- EXEC, lw/sw: ALUOut=A+sext(imm), go to MEM.
- EXEC, beq/bne: pc ← target if taken, else pc+4. Retire, go to FETCH.
- EXEC, j: pc ← {pc[31:28],imm26,2'b00}. Retire, go to FETCH.
- EXEC, jal: same as j, and also r31 ← pc+4. Retire, go to FETCH.
- EXEC, jr: pc ← A. Retire, go to FETCH.
- MEM: mem_req=1, mem_addr=ALUOut, mem_we=1 for sw with mem_wdata=B.
- MEM, sw on accept: pc ← pc+4, retire, go to FETCH.
- MEM, lw on accept: latch MDR, go to WB.
- WB: write rd (R-type) or rt (addi/lw). pc ← pc+4, retire, go to FETCH.
- HALT: terminal. Only reset leaves it; mem_req=0.
- Writes to r0 are discarded, and result is then not updated. r0 always reads 0.
- Arithmetic is 32-bit two's complement and wraps; no overflow trap.
- slt is a signed compare. sll uses shamt.
- PC increments wrap mod 2^32.
- Addresses are not alignment-checked. mem_addr = addr[ADDR_W-1:0].

## Timing
- Reset values: pc=RESET_PC, all registers 0, result=0, retired=0, halted=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state=FETCH.
- mem_req asserts in the first cycle after reset deasserts.
- Handshake: while mem_req=1, mem_addr, mem_we and mem_wdata stay stable until the accepting edge. mem_req drops in the next cycle; there are no back-to-back requests without a state change.
- Cycles with mem_ready tied 1:
  - branch, j, jal, jr: 3
  - sw: 4
  - R-type, addi: 4
  - lw: 5
- Each wait cycle on mem_ready adds one cycle to FETCH or MEM.
- retired pulses in the final cycle of an instruction. The register/pc update is visible on the following cycle.
- Reset asserted mid-operation: the access is abandoned and mem_req=0 in the cycle after the reset edge. No register or pc update from the aborted instruction. A write in flight is not completed by the core.
- jal followed immediately by jr r31 returns correctly; no forwarding hazards exist in a multi-cycle design.

## Test plan
- ALU, zero-wait memory: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1. Expect r3=2, r4=1, result=1, retired pulses at cycles 4/8/12/16 after reset release.
- Load/store with wait states: sw r1,8(r0) then lw r5,8(r0), mem_ready low 3 cycles per access. Expect mem_we=1, addr=8, wdata=5 held stable through the waits. Expect r5=5, each instruction +6 cycles.
- Control flow: beq taken (offset +2) skips 2 instructions; bne not taken falls through. jal at pc 0x10 sets r31=0x14; jr r31 returns to 0x14.
- r0 and wrap: addi r0,r0,7 leaves r0=0 and result unchanged. add of 0x7FFFFFFF+1 gives 0x80000000 with no trap.
- Illegal opcode 0x3F: with ILLEGAL_HALT=1, halted=1 and mem_req stays 0. With ILLEGAL_HALT=0, it retires as NOP in 3 cycles with pc+4.
- Reset during a stalled lw MEM phase: mem_req=0 next cycle, pc=RESET_PC, registers cleared, fetch restarts cleanly.
